// File: rtl/alu_share_ctrl.sv
// Shares one 32-bit ALU between two requesters: arbitration, operand hold while the ALU settles, result return.
// Define ALU_SHARE_PRIO_EN for fixed priority (req0 always wins); default build is round-robin.
module alu_share_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [4:0]  req0_shamt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [4:0]  req1_shamt,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_zero
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       lat_id;
  logic       grant0;
  logic       grant1;
  logic       accept;

`ifdef ALU_SHARE_PRIO_EN
  always_comb begin
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`else
  logic last_grant;

  // last_grant==1 means req1 won last time, so req0 takes the next contended grant.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last_grant);
    grant1 = req1_valid & (~req0_valid | ~last_grant);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant1;
    end
  end
`endif

  always_comb begin
    req0_ready = (state == IDLE) & grant0;
    req1_ready = (state == IDLE) & grant1;
    accept     = req0_ready | req1_ready;
  end

  // rsp_valid rises one cycle after capture, giving SETTLE_CYCLES+1 accept-to-valid latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_id      <= 1'b0;
      alu_control <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_shamt   <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_control <= grant1 ? req1_op    : req0_op;
            alu_a       <= grant1 ? req1_a     : req0_a;
            alu_b       <= grant1 ? req1_b     : req0_b;
            alu_shamt   <= grant1 ? req1_shamt : req0_shamt;
            lat_id      <= grant1;
            cnt         <= CNT_LOAD;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) begin
            rsp_result <= alu_result;
            rsp_zero   <= alu_zero;
            rsp_id     <= lat_id;
            state      <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: ALU modelled behaviourally, second instance with SETTLE_CYCLES=1.
module tb_alu_share_ctrl;

  localparam int unsigned S = 4;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero;
  logic [31:0] rsp_result;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [4:0]  alu_shamt;
  logic        alu_zero;

  logic        s_reset;
  logic        s_req0_valid, s_req0_ready, s_req1_valid, s_req1_ready;
  logic [3:0]  s_req0_op, s_req1_op;
  logic [31:0] s_req0_a, s_req0_b, s_req1_a, s_req1_b;
  logic [4:0]  s_req0_shamt, s_req1_shamt;
  logic        s_rsp_valid, s_rsp_ready, s_rsp_id, s_rsp_zero;
  logic [31:0] s_rsp_result;
  logic [3:0]  s_alu_control;
  logic [31:0] s_alu_a, s_alu_b, s_alu_result;
  logic [4:0]  s_alu_shamt;
  logic        s_alu_zero;

  int checks;
  int failures;
  logic exp_g [4];

  alu_share_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_shamt(req0_shamt),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_shamt(req1_shamt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_control(alu_control), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  alu_share_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(s_reset),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_op(s_req0_op),
    .req0_a(s_req0_a), .req0_b(s_req0_b), .req0_shamt(s_req0_shamt),
    .req1_valid(s_req1_valid), .req1_ready(s_req1_ready), .req1_op(s_req1_op),
    .req1_a(s_req1_a), .req1_b(s_req1_b), .req1_shamt(s_req1_shamt),
    .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_id(s_rsp_id),
    .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero),
    .alu_control(s_alu_control), .alu_a(s_alu_a), .alu_b(s_alu_b), .alu_shamt(s_alu_shamt),
    .alu_result(s_alu_result), .alu_zero(s_alu_zero)
  );

  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic [4:0] sh);
    case (op)
      4'b0000: alu_fn = a & b;
      4'b0001: alu_fn = a - b;
      4'b0010: alu_fn = a + b;
      4'b0100: alu_fn = a << sh;
      4'b0110: alu_fn = a | b;
      4'b0111: alu_fn = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: alu_fn = ~(a | b);
      default: alu_fn = '0;
    endcase
  endfunction

  always_comb begin
    alu_result   = alu_fn(alu_control, alu_a, alu_b, alu_shamt);
    alu_zero     = (alu_result == 32'd0);
    s_alu_result = alu_fn(s_alu_control, s_alu_a, s_alu_b, s_alu_shamt);
    s_alu_zero   = (s_alu_result == 32'd0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // One operation from a single requester, with rsp_ready held high throughout.
  task automatic run_op(input logic id, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh,
                        input logic [31:0] er, input logic ez);
    int unsigned n;
    rsp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; req1_shamt = sh;
    end else begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; req0_shamt = sh;
    end
    #1;
    chk1("op_ready_winner", id ? req1_ready : req0_ready, 1'b1);
    chk1("op_ready_other", id ? req0_ready : req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk32("op_alu_control", 32'(alu_control), 32'(op));
    chk32("op_alu_a", alu_a, a);
    chk32("op_alu_b", alu_b, b);
    chk32("op_alu_shamt", 32'(alu_shamt), 32'(sh));
    n = 0;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
      chk32("op_alu_a_stable", alu_a, a);
      chk32("op_alu_b_stable", alu_b, b);
      chk32("op_alu_shamt_stable", 32'(alu_shamt), 32'(sh));
    end
    chk32("op_latency", n, S + 1);
    chk32("op_result", rsp_result, er);
    chk1("op_zero", rsp_zero, ez);
    chk1("op_id", rsp_id, id);
    step();
    chk1("op_rsp_done", rsp_valid, 1'b0);
  endtask

  initial begin
    int unsigned n;
    int unsigned seen;
    int rdy [4];
    int val [3];
    int nr, nv;
    logic g;
    checks = 0;
    failures = 0;
`ifdef ALU_SHARE_PRIO_EN
    exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_g[2] = 1'b0; exp_g[3] = 1'b0;
`else
    exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;
`endif
    reset = 1'b1; s_reset = 1'b1;
    req0_valid = 1'b0; req0_op = '0; req0_a = '0; req0_b = '0; req0_shamt = '0;
    req1_valid = 1'b0; req1_op = '0; req1_a = '0; req1_b = '0; req1_shamt = '0;
    rsp_ready = 1'b0;
    s_req0_valid = 1'b0; s_req0_op = '0; s_req0_a = '0; s_req0_b = '0; s_req0_shamt = '0;
    s_req1_valid = 1'b0; s_req1_op = '0; s_req1_a = '0; s_req1_b = '0; s_req1_shamt = '0;
    s_rsp_ready = 1'b0;
    step();
    step();
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chk32("rst_rsp_result", rsp_result, 32'd0);
    chk32("rst_alu_a", alu_a, 32'd0);
    chk32("rst_alu_control", 32'(alu_control), 32'd0);
    chk1("rst_req0_ready", req0_ready, 1'b0);
    reset = 1'b0;
    s_reset = 1'b0;
    step();

    // Single ADD 5+7 from req0
    run_op(1'b0, 4'b0010, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0);

    // Contention from both requesters, starting from a fresh reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 32'd9;    req0_b = 32'd9;    req0_shamt = '0;
    req1_valid = 1'b1; req1_op = 4'b0110; req1_a = 32'hF0;   req1_b = 32'h0F;   req1_shamt = '0;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(req0_ready || req1_ready) && n < 20) begin
        step();
        n++;
      end
      chk1("rr_grant_seen", n < 20, 1'b1);
      chk1("rr_grant_id", req1_ready, exp_g[k]);
      chk1("rr_single_ready", req0_ready & req1_ready, 1'b0);
      g = req1_ready;
      step();
      n = 0;
      while (!rsp_valid && n < 20) begin
        step();
        n++;
      end
      chk1("rr_rsp_id", rsp_id, exp_g[k]);
      chk32("rr_rsp_result", rsp_result, exp_g[k] ? 32'hFF : 32'h0);
      chk1("rr_rsp_zero", rsp_zero, ~exp_g[k]);
      chk1("rr_id_matches_grant", rsp_id, g);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();

    // Back-pressure: rsp_ready low for 10 cycles in RESP
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 32'hFFFF0000; req1_b = 32'h0FF00000;
    #1;
    chk1("bp_req1_ready", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      step();
      n++;
    end
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd1; req0_b = 32'd1;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk1("bp_rsp_valid", rsp_valid, 1'b1);
      chk32("bp_rsp_result", rsp_result, 32'h0FF00000);
      chk1("bp_rsp_id", rsp_id, 1'b1);
      chk1("bp_req0_ready", req0_ready, 1'b0);
      chk1("bp_req1_ready_busy", req1_ready, 1'b0);
      step();
    end
    rsp_ready = 1'b1;
    chk1("bp_still_valid", rsp_valid, 1'b1);
    step();
    chk1("bp_handshake_done", rsp_valid, 1'b0);
    chk1("bp_idle_ready", req0_ready, 1'b1);
    req0_valid = 1'b0;
    #1;
    chk1("drop_ready", req0_ready, 1'b0);
    step();
    step();
    chk32("drop_alu_a_held", alu_a, 32'hFFFF0000);
    chk32("drop_alu_control_held", 32'(alu_control), 32'd0);
    chk1("drop_no_rsp", rsp_valid, 1'b0);

    // Reset in the middle of SETTLE
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd3; req0_b = 32'd4;
    #1;
    step();
    req0_valid = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk1("mid_rst_rsp_valid", rsp_valid, 1'b0);
    chk32("mid_rst_alu_a", alu_a, 32'd0);
    chk32("mid_rst_alu_b", alu_b, 32'd0);
    chk32("mid_rst_alu_control", 32'(alu_control), 32'd0);
    req1_valid = 1'b1;
    #1;
    chk1("mid_rst_idle", req1_ready, 1'b1);
    req1_valid = 1'b0;
    #1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (rsp_valid) seen++;
    end
    chk32("mid_rst_no_rsp", seen, 32'd0);

    // SLT, SLL boundary shift, NOR
    run_op(1'b0, 4'b0111, 32'd3, 32'd8, 5'd0, 32'd1, 1'b0);
    run_op(1'b0, 4'b0100, 32'd1, 32'd0, 5'd31, 32'h80000000, 1'b0);
    run_op(1'b1, 4'b1100, 32'd0, 32'd0, 5'd0, 32'hFFFFFFFF, 1'b0);

    // SETTLE_CYCLES=1 instance: latency 2, one op every 4 cycles
    s_rsp_ready = 1'b1;
    s_req0_valid = 1'b1; s_req0_op = 4'b0010; s_req0_a = 32'd2; s_req0_b = 32'd3;
    #1;
    nr = 0; nv = 0;
    for (int i = 0; i < 4; i++) rdy[i] = 0;
    for (int i = 0; i < 3; i++) val[i] = 0;
    for (int c = 0; c < 30; c++) begin
      if (s_req0_ready && nr < 4) begin
        rdy[nr] = c;
        nr++;
      end
      if (s_rsp_valid && nv < 3) begin
        val[nv] = c;
        nv++;
        chk32("s1_result", s_rsp_result, 32'd5);
      end
      step();
    end
    s_req0_valid = 1'b0;
    chk32("s1_grant_count", 32'(nr), 32'd4);
    chk32("s1_latency", 32'(val[0] - rdy[0]), 32'd3);
    chk32("s1_period_a", 32'(rdy[1] - rdy[0]), 32'd4);
    chk32("s1_period_b", 32'(rdy[2] - rdy[1]), 32'd4);
    chk32("s1_period_c", 32'(rdy[3] - rdy[2]), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
